// File: rtl/issue_pkg.sv
// Shared definitions for the issue controller.
//   REG_IDX_W : width of a register index (x0..x31)
//   NUM_REGS  : number of architectural registers
//   state_e   : issue controller states
package issue_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, set when a
// register-writing instruction issues and cleared at its writeback.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   flush_i                clear every busy bit at the next edge
//   set_i / set_rd_i       mark set_rd_i busy (writing issue)
//   wb_valid_i / wb_rd_i   writeback retiring wb_rd_i
//   use_rs1_i / sel_rs1_i  source 1 lookup
//   use_rs2_i / sel_rs2_i  source 2 lookup
//   wr_rd_i / rd_i         destination lookup (WAW)
//   hazard_o               any source or WAW hazard this cycle
module reg_scoreboard
  import issue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 set_i,
  input  logic [REG_IDX_W-1:0] set_rd_i,
  input  logic                 wb_valid_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic                 use_rs1_i,
  input  logic [REG_IDX_W-1:0] sel_rs1_i,
  input  logic                 use_rs2_i,
  input  logic [REG_IDX_W-1:0] sel_rs2_i,
  input  logic                 wr_rd_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  output logic                 hazard_o
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rs1_haz;
  logic                rs2_haz;
  logic                waw_haz;

  // Clear before set so a same-cycle issue to the retiring register wins;
  // x0 is forced clear so it can never report busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid_i) busy_nxt[wb_rd_i] = 1'b0;
    if (set_i)      busy_nxt[set_rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          busy <= '0;
    else if (flush_i) busy <= '0;
    else              busy <= busy_nxt;
  end

  // A writeback retiring the register this cycle bypasses the hazard.
  assign rs1_haz = use_rs1_i & busy[sel_rs1_i] & ~(wb_valid_i & (wb_rd_i == sel_rs1_i));
  assign rs2_haz = use_rs2_i & busy[sel_rs2_i] & ~(wb_valid_i & (wb_rd_i == sel_rs2_i));
  assign waw_haz = wr_rd_i & (rd_i != '0) & busy[rd_i] & ~(wb_valid_i & (wb_rd_i == rd_i));

  assign hazard_o = rs1_haz | rs2_haz | waw_haz;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: decides each cycle whether the decoded instruction may
// go to execute, tracking outstanding register writes and flushes.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   dec_valid_i               decode holds an instruction
//   sel_rs1_i/sel_rs2_i       source selects, use_rs1_i/use_rs2_i qualify them
//   rd_i, wr_rd_i             destination and its write enable
//   ex_ready_i                execute can accept
//   wb_valid_i, wb_rd_i       writeback retiring one register
//   flush_i                   squash everything in flight
//   issue_o                   instruction issued (decode-ready)
//   stall_o                   decode valid but not issued
//   stall_cnt_o               saturating stall-cycle count
//   err_o                     sticky: writeback seen with nothing in flight
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid_i,
  input  logic [REG_IDX_W-1:0] sel_rs1_i,
  input  logic [REG_IDX_W-1:0] sel_rs2_i,
  input  logic                 use_rs1_i,
  input  logic                 use_rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 wr_rd_i,
  input  logic                 ex_ready_i,
  input  logic                 wb_valid_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic                 flush_i,
  output logic                 issue_o,
  output logic                 stall_o,
  output logic [15:0]          stall_cnt_o,
  output logic                 err_o
);

  localparam int             CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e           state;
  logic [CNT_W-1:0] inflight;
  logic             hazard;
  logic             cap_stall;
  logic             can_issue;
  logic             wr_issue;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .set_i      (wr_issue),
    .set_rd_i   (rd_i),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .use_rs1_i  (use_rs1_i),
    .sel_rs1_i  (sel_rs1_i),
    .use_rs2_i  (use_rs2_i),
    .sel_rs2_i  (sel_rs2_i),
    .wr_rd_i    (wr_rd_i),
    .rd_i       (rd_i),
    .hazard_o   (hazard)
  );

  // A same-cycle writeback frees a slot, so a full tracker does not block.
  assign cap_stall = wr_rd_i & (inflight == CNT_MAX) & ~wb_valid_i;
  assign can_issue = (state == RUN) | (state == STALL);
  assign issue_o   = dec_valid_i & ex_ready_i & can_issue & ~flush_i & ~hazard & ~cap_stall;
  assign stall_o   = dec_valid_i & ~issue_o;
  // Writes to x0 are discarded and are never tracked.
  assign wr_issue  = issue_o & wr_rd_i & (rd_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else if (flush_i) begin
      state <= FLUSH;
    end else begin
      case (state)
        RUN:     if (dec_valid_i & ~issue_o) state <= STALL;
        STALL:   if (issue_o | ~dec_valid_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (flush_i) begin
      inflight <= '0;
    end else if (wr_issue & ~wb_valid_i) begin
      inflight <= inflight + 1'b1;
    end else if (~wr_issue & wb_valid_i & (inflight != '0)) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (wb_valid_i & (inflight == '0)) err_o <= 1'b1;
      if (stall_o) stall_cnt_o <= sat_inc16(stall_cnt_o);
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;

  localparam int MAXI = 4;

  logic        clk;
  logic        rst;
  logic        dec_valid_i;
  logic [4:0]  sel_rs1_i;
  logic [4:0]  sel_rs2_i;
  logic        use_rs1_i;
  logic        use_rs2_i;
  logic [4:0]  rd_i;
  logic        wr_rd_i;
  logic        ex_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        issue_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  // Reference model: set of registers with a pending write, number of
  // pending writes, whether last cycle was a flush request, stall tally.
  bit m_busy[32];
  int m_cnt;
  bit m_flushing;
  bit m_err;
  int m_stall;
  bit e_iss;
  bit e_stall;

  issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid_i (dec_valid_i),
    .sel_rs1_i   (sel_rs1_i),
    .sel_rs2_i   (sel_rs2_i),
    .use_rs1_i   (use_rs1_i),
    .use_rs2_i   (use_rs2_i),
    .rd_i        (rd_i),
    .wr_rd_i     (wr_rd_i),
    .ex_ready_i  (ex_ready_i),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .flush_i     (flush_i),
    .issue_o     (issue_o),
    .stall_o     (stall_o),
    .stall_cnt_o (stall_cnt_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_cnt      = 0;
    m_flushing = 1'b0;
    m_err      = 1'b0;
    m_stall    = 0;
  endtask

  task automatic idle();
    dec_valid_i = 1'b0;
    sel_rs1_i   = '0;
    sel_rs2_i   = '0;
    use_rs1_i   = 1'b0;
    use_rs2_i   = 1'b0;
    rd_i        = '0;
    wr_rd_i     = 1'b0;
    ex_ready_i  = 1'b1;
    wb_valid_i  = 1'b0;
    wb_rd_i     = '0;
    flush_i     = 1'b0;
  endtask

  task automatic wr_instr(input logic [4:0] rd, input bit use1, input logic [4:0] rs1);
    idle();
    dec_valid_i = 1'b1;
    wr_rd_i     = 1'b1;
    rd_i        = rd;
    use_rs1_i   = use1;
    sel_rs1_i   = rs1;
  endtask

  // Predict combinational outputs from the model and compare mid-cycle.
  task automatic eval();
    bit h1, h2, hw, cap;
    @(negedge clk);
    h1  = use_rs1_i && m_busy[sel_rs1_i] && !(wb_valid_i && wb_rd_i == sel_rs1_i);
    h2  = use_rs2_i && m_busy[sel_rs2_i] && !(wb_valid_i && wb_rd_i == sel_rs2_i);
    hw  = wr_rd_i && rd_i != 0 && m_busy[rd_i] && !(wb_valid_i && wb_rd_i == rd_i);
    cap = wr_rd_i && m_cnt == MAXI && !wb_valid_i;
    e_iss   = dec_valid_i && ex_ready_i && !flush_i && !m_flushing && !h1 && !h2 && !hw && !cap;
    e_stall = dec_valid_i && !e_iss;
    chk("issue", 16'(issue_o), 16'(e_iss));
    chk("stall", 16'(stall_o), 16'(e_stall));
    chk("stall_cnt", stall_cnt_o, 16'(m_stall));
    chk("err", 16'(err_o), 16'(m_err));
  endtask

  // Advance the model across the clock edge.
  task automatic commit();
    bit writing;
    @(posedge clk);
    writing = e_iss && wr_rd_i && rd_i != 0;
    if (wb_valid_i && m_cnt == 0) m_err = 1'b1;
    if (e_stall && m_stall < 65535) m_stall++;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_cnt = 0;
    end else begin
      if (wb_valid_i) m_busy[wb_rd_i] = 1'b0;
      if (writing) m_busy[rd_i] = 1'b1;
      if (writing && !wb_valid_i) m_cnt++;
      else if (!writing && wb_valid_i && m_cnt > 0) m_cnt--;
    end
    m_flushing = flush_i;
    #1;
  endtask

  task automatic cyc();
    eval();
    commit();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #3;
    chk("rst_stall_cnt", stall_cnt_o, 16'h0000);
    chk("rst_err", 16'(err_o), 16'h0000);
    chk("rst_issue", 16'(issue_o), 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // RAW hazard resolved by same-cycle writeback
    wr_instr(5'd5, 1'b0, 5'd0);
    eval(); chk("raw_first", 16'(issue_o), 16'h1); commit();
    wr_instr(5'd6, 1'b1, 5'd5);
    eval(); chk("raw_block_iss", 16'(issue_o), 16'h0); chk("raw_block_stall", 16'(stall_o), 16'h1); commit();
    wb_valid_i = 1'b1; wb_rd_i = 5'd5;
    eval(); chk("raw_bypass", 16'(issue_o), 16'h1); commit();
    idle(); wb_valid_i = 1'b1; wb_rd_i = 5'd6;
    cyc();

    // Capacity limit
    for (int r = 1; r <= 4; r++) begin
      wr_instr(5'(r), 1'b0, 5'd0);
      eval(); chk("cap_fill", 16'(issue_o), 16'h1); commit();
    end
    wr_instr(5'd7, 1'b0, 5'd0);
    eval(); chk("cap_full", 16'(issue_o), 16'h0); commit();
    wb_valid_i = 1'b1; wb_rd_i = 5'd1;
    eval(); chk("cap_wb_same", 16'(issue_o), 16'h1); commit();
    wr_instr(5'd8, 1'b0, 5'd0);
    eval(); chk("cap_still_full", 16'(issue_o), 16'h0); commit();
    for (int r = 2; r <= 4; r++) begin
      idle(); wb_valid_i = 1'b1; wb_rd_i = 5'(r); cyc();
    end
    idle(); wb_valid_i = 1'b1; wb_rd_i = 5'd7; cyc();

    // x0 never tracked
    for (int k = 0; k < 6; k++) begin
      wr_instr(5'd0, 1'b0, 5'd0);
      eval(); chk("x0_write", 16'(issue_o), 16'h1); commit();
    end
    wr_instr(5'd9, 1'b1, 5'd0);
    eval(); chk("x0_read", 16'(issue_o), 16'h1); commit();
    for (int r = 10; r <= 12; r++) begin
      wr_instr(5'(r), 1'b0, 5'd0);
      eval(); chk("x0_cnt", 16'(issue_o), 16'h1); commit();
    end
    wr_instr(5'd13, 1'b0, 5'd0);
    eval(); chk("x0_cnt_full", 16'(issue_o), 16'h0); commit();

    // Flush with a same-cycle issue attempt
    wr_instr(5'd14, 1'b0, 5'd0); flush_i = 1'b1;
    eval(); chk("flush_iss", 16'(issue_o), 16'h0); chk("flush_stall", 16'(stall_o), 16'h1); commit();
    wr_instr(5'd15, 1'b1, 5'd9);
    eval(); chk("flush_state_iss", 16'(issue_o), 16'h0); commit();
    eval(); chk("post_flush_dep", 16'(issue_o), 16'h1); commit();
    for (int r = 16; r <= 18; r++) begin
      wr_instr(5'(r), 1'b0, 5'd0);
      eval(); chk("post_flush_cnt", 16'(issue_o), 16'h1); commit();
    end
    wr_instr(5'd19, 1'b0, 5'd0);
    eval(); chk("post_flush_full", 16'(issue_o), 16'h0); commit();
    idle(); flush_i = 1'b1; cyc();
    idle(); cyc();

    // Spurious writeback sets sticky error
    idle(); wb_valid_i = 1'b1; wb_rd_i = 5'd3; cyc();
    idle();
    eval(); chk("err_set", 16'(err_o), 16'h1); commit();
    for (int k = 0; k < 3; k++) cyc();

    // Asynchronous reset in the middle of a stall
    wr_instr(5'd5, 1'b0, 5'd0); cyc();
    idle(); dec_valid_i = 1'b1; use_rs1_i = 1'b1; sel_rs1_i = 5'd5;
    for (int k = 0; k < 3; k++) cyc();
    rst = 1'b1;
    #1;
    chk("arst_stall_cnt", stall_cnt_o, 16'h0000);
    chk("arst_err", 16'(err_o), 16'h0000);
    idle();
    #1;
    chk("arst_issue", 16'(issue_o), 16'h0000);
    chk("arst_stall", 16'(stall_o), 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    dec_valid_i = 1'b1; use_rs1_i = 1'b1; sel_rs1_i = 5'd5;
    eval(); chk("arst_forgot", 16'(issue_o), 16'h1); commit();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      dec_valid_i = 1'($urandom_range(0, 3) != 0);
      sel_rs1_i   = 5'($urandom_range(0, 7));
      sel_rs2_i   = 5'($urandom_range(0, 7));
      use_rs1_i   = 1'($urandom_range(0, 1));
      use_rs2_i   = 1'($urandom_range(0, 1));
      rd_i        = 5'($urandom_range(0, 7));
      wr_rd_i     = 1'($urandom_range(0, 3) != 0);
      ex_ready_i  = 1'($urandom_range(0, 4) != 0);
      wb_valid_i  = 1'($urandom_range(0, 9) < 3);
      wb_rd_i     = 5'($urandom_range(0, 7));
      flush_i     = 1'($urandom_range(0, 29) == 0);
      cyc();
    end

    // Long stall saturates the counter
    idle(); flush_i = 1'b1; cyc();
    idle(); cyc();
    wr_instr(5'd3, 1'b0, 5'd0); cyc();
    idle(); dec_valid_i = 1'b1; use_rs1_i = 1'b1; sel_rs1_i = 5'd3;
    for (int k = 0; k < 70000; k++) cyc();
    eval(); chk("stall_sat", stall_cnt_o, 16'hFFFF); commit();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
